// File: rtl/alarm_clk_pkg.sv
// Shared types and constants for the alarm-clock button front end.
// Holds the button code type, button index names, control FSM state
// encoding, default timing constants and the priority-encoder helper.
package alarm_clk_pkg;

  localparam int BTN_COUNT = 4;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t BTN_SET_HOUR = 2'd0;
  localparam btn_code_t BTN_SET_MIN  = 2'd1;
  localparam btn_code_t BTN_ALARM    = 2'd2;
  localparam btn_code_t BTN_MODE     = 2'd3;

  // Default timing for a 100 MHz clock.
  localparam int DEBOUNCE_DEFAULT      = 500000;    // 5 ms
  localparam int REPEAT_DELAY_DEFAULT  = 50000000;  // 500 ms
  localparam int REPEAT_PERIOD_DEFAULT = 20000000;  // 200 ms

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } btn_state_t;

  // Highest index wins; losing rises are simply ignored.
  function automatic btn_code_t prio_encode(input logic [BTN_COUNT-1:0] rise);
    btn_code_t code;
    if (rise[3])      code = BTN_MODE;
    else if (rise[2]) code = BTN_ALARM;
    else if (rise[1]) code = BTN_SET_MIN;
    else              code = BTN_SET_HOUR;
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser followed by a debounce
// counter. A level change is accepted only after DEBOUNCE_CYCLES
// consecutive clocks of disagreement between the synchronised input and
// the current stable level; any agreement restarts the count.
module btn_debounce
  import alarm_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Next-state for the synchroniser chain and the debounce counter.
  always_comb begin
    meta_d   = btn_raw;
    sync_d   = meta_q;
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any partial debounce progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/button_encoder4x2.sv
// Four push-buttons to one debounced key event (2-bit code + 1-cycle
// valid strobe). Each button is synchronised and debounced, new presses
// are detected as rising edges of the debounced level, the highest index
// wins, and further presses are locked out until all buttons are released.
// Optional feature: define BTN_AUTOREPEAT_EN to re-emit the held winning
// button after REPEAT_DELAY clocks and then every REPEAT_PERIOD clocks.
module button_encoder4x2
  import alarm_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_COUNT-1:0] btn_in,
  output logic [1:0]           code,
  output logic                 valid,
  output logic [BTN_COUNT-1:0] pressed,
  output logic                 busy
);

  // Reject configurations that would break the one-cycle strobe contract.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_encoder4x2: DEBOUNCE_CYCLES>=2, REPEAT_DELAY>=1, REPEAT_PERIOD>=2 required");
  end

  logic [BTN_COUNT-1:0] stable;
  logic [BTN_COUNT-1:0] stable_dly_q, stable_dly_d;
  logic [BTN_COUNT-1:0] rise;

  btn_state_t state_q, state_d;
  btn_code_t  code_q, code_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_in[i]),
      .stable (stable[i])
    );
  end

  assign rise = stable & ~stable_dly_q;

  // Control FSM next-state: accept one press, then lock out until release.
  always_comb begin
    stable_dly_d = stable;
    state_d      = state_q;
    code_d       = code_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
`ifdef BTN_AUTOREPEAT_EN
    hold_cnt_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          code_d  = prio_encode(rise);
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          state_d = ST_HOLD;
`else
          state_d = ST_LOCKED;
`endif
        end
      end
      ST_LOCKED: begin
        if (stable == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      ST_HOLD, ST_REPEAT: begin
        if (!stable[code_q]) begin
          // Winner released: finish immediately if nothing else is held,
          // otherwise wait without repeats.
          if (stable == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (hold_cnt_q == ((state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
          valid_d = 1'b1;
          state_d = ST_REPEAT;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs; reset drops all progress and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_dly_q <= '0;
      state_q      <= ST_IDLE;
      code_q       <= BTN_SET_HOUR;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      hold_cnt_q   <= '0;
`endif
    end else begin
      stable_dly_q <= stable_dly_d;
      state_q      <= state_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_cnt_q   <= hold_cnt_d;
`endif
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign pressed = stable;

endmodule
